attn_sequencer: RTL and testbench

Parametrised successor to the single-tile attention controller. It sequences Q/K memory writes, K-weight loading, execution, psum write-back, and optional normalisation for the 1D MAC core. It iterates over `num_ktile` K tiles instead of a fixed two passes, and makes address width and drain length parameters. It drives the core instruction bus directly, adds `busy`/`done`/`abort` handshakes, and sits between the testbench/top-level host and `core`.

---
 rtl/attn_sequencer.sv | 254 +++++++++++++++++++++++++
 tb/tb_attn_sequencer.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/attn_sequencer.sv
// attn_sequencer: multi-tile attention controller driving the 1D MAC core.
// Sequences Q/K writes, K load, execute, psum write-back and normalisation.
module attn_sequencer #(
    parameter int col         = 8,
    parameter int total_cycle = 8,
    parameter int num_ktile   = 2,
    parameter int addr_w      = 4,
    parameter int drain       = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 norm_en,
    input  logic                 abort,
    input  logic                 fifo_in_ready,
    output logic [11+2*addr_w:0] inst,
    output logic                 busy,
    output logic                 done
);
    localparam int SPAN = (col > total_cycle) ? col : total_cycle;
    localparam int M1   = (col + 2 > total_cycle + 1) ? col + 2 : total_cycle + 1;
    localparam int CMAX = (M1 > drain) ? M1 : drain;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int TW   = (num_ktile > 1) ? $clog2(num_ktile) : 1;
    localparam int IW   = 12 + 2 * addr_w;

    if (num_ktile < 1) begin : g_chk_tiles
        $error("attn_sequencer: num_ktile must be at least 1");
    end
    if (num_ktile * SPAN > 2 ** addr_w) begin : g_chk_addr
        $error("attn_sequencer: addr_w too small for the tile footprint");
    end
    if (drain < col + 2) begin : g_chk_drain
        $error("attn_sequencer: drain shorter than the array flush");
    end

    localparam int I_PWR = 0;
    localparam int I_PRD = 1;
    localparam int I_KWR = 2;
    localparam int I_KRD = 3;
    localparam int I_QWR = 4;
    localparam int I_QRD = 5;
    localparam int I_LD  = 6;
    localparam int I_EX  = 7;
    localparam int I_PA  = 8;
    localparam int I_QK  = 8 + addr_w;
    localparam int I_OF  = 8 + 2 * addr_w;
    localparam int I_ACC = 9 + 2 * addr_w;
    localparam int I_DIV = 10 + 2 * addr_w;
    localparam int I_FX  = 11 + 2 * addr_w;

    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_QWR  = 4'd1;
    localparam logic [3:0] S_KWR  = 4'd2;
    localparam logic [3:0] S_KLD  = 4'd3;
    localparam logic [3:0] S_DRL  = 4'd4;
    localparam logic [3:0] S_EXE  = 4'd5;
    localparam logic [3:0] S_DRE  = 4'd6;
    localparam logic [3:0] S_PSW  = 4'd7;
    localparam logic [3:0] S_FET  = 4'd8;
    localparam logic [3:0] S_FSM  = 4'd9;
    localparam logic [3:0] S_WIN  = 4'd10;
    localparam logic [3:0] S_NRM  = 4'd11;
    localparam logic [3:0] S_NPW  = 4'd12;

    localparam logic [CW-1:0]     C_COL  = CW'(col);
    localparam logic [CW-1:0]     C_COL1 = CW'(col + 1);
    localparam logic [CW-1:0]     C_TC   = CW'(total_cycle);
    localparam logic [CW-1:0]     C_DR1  = CW'(drain - 1);
    localparam logic [TW-1:0]     T_LAST = TW'(num_ktile - 1);
    localparam logic [addr_w-1:0] A_COL  = addr_w'(col);
    localparam logic [addr_w-1:0] A_TC   = addr_w'(total_cycle);

    logic [3:0]        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [TW-1:0]     tile_q, tile_d;
    logic              norm_q, norm_d;
    logic [IW-1:0]     inst_q, inst_d;
    logic              done_q, done_d;
    logic              tile_end;
    logic [addr_w-1:0] cnt_a, tile_a, qk_base, pm_base;

    assign cnt_a   = addr_w'(cnt_q);
    assign tile_a  = addr_w'(tile_q);
    assign qk_base = tile_a * A_COL;
    assign pm_base = tile_a * A_TC;

    // Phase sequencing; inst_d is the strobe word for the current slot.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CW'(1);
        tile_d   = tile_q;
        norm_d   = norm_q;
        inst_d   = '0;
        done_d   = 1'b0;
        tile_end = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    state_d = S_QWR;
                    tile_d  = '0;
                    norm_d  = norm_en;
                end
            end
            S_QWR: begin
                if (cnt_q < C_TC) begin
                    inst_d[I_QWR]          = 1'b1;
                    inst_d[I_QK +: addr_w] = cnt_a;
                end else begin
                    state_d = S_KWR;
                    cnt_d   = '0;
                end
            end
            S_KWR: begin
                if (cnt_q < C_COL) begin
                    inst_d[I_KWR]          = 1'b1;
                    inst_d[I_QK +: addr_w] = qk_base + cnt_a;
                end else begin
                    state_d = S_KLD;
                    cnt_d   = '0;
                end
            end
            S_KLD: begin
                if (cnt_q <= C_COL) begin
                    inst_d[I_LD] = 1'b1;
                end
                if (cnt_q != '0 && cnt_q <= C_COL) begin
                    inst_d[I_KRD]          = 1'b1;
                    inst_d[I_QK +: addr_w] = qk_base + cnt_a - addr_w'(1);
                end
                if (cnt_q == C_COL1) begin
                    state_d = S_DRL;
                    cnt_d   = '0;
                end
            end
            S_DRL: begin
                if (cnt_q == C_DR1) begin
                    state_d = S_EXE;
                    cnt_d   = '0;
                end
            end
            S_EXE: begin
                if (cnt_q < C_TC) begin
                    inst_d[I_EX]           = 1'b1;
                    inst_d[I_QRD]          = 1'b1;
                    inst_d[I_QK +: addr_w] = cnt_a;
                end else begin
                    state_d = S_DRE;
                    cnt_d   = '0;
                end
            end
            S_DRE: begin
                if (cnt_q == C_DR1) begin
                    state_d = S_PSW;
                    cnt_d   = '0;
                end
            end
            S_PSW, S_NPW: begin
                if (cnt_q < C_TC) begin
                    inst_d[I_OF]           = 1'b1;
                    inst_d[I_PWR]          = 1'b1;
                    inst_d[I_PA +: addr_w] = pm_base + cnt_a;
                end else if (state_q == S_PSW && norm_q) begin
                    state_d = S_FET;
                    cnt_d   = '0;
                end else begin
                    tile_end = 1'b1;
                end
            end
            S_FET: begin
                if (cnt_q < C_TC) begin
                    inst_d[I_PRD]          = 1'b1;
                    inst_d[I_PA +: addr_w] = pm_base + cnt_a;
                end
                if (cnt_q != '0) begin
                    inst_d[I_ACC] = 1'b1;
                end
                if (cnt_q == C_TC) begin
                    state_d = S_FSM;
                    cnt_d   = '0;
                end
            end
            S_FSM: begin
                if (cnt_q < C_TC) begin
                    inst_d[I_FX] = 1'b1;
                end else begin
                    state_d = S_WIN;
                    cnt_d   = '0;
                end
            end
            S_WIN: begin
                cnt_d = '0;
                if (fifo_in_ready) begin
                    state_d = S_NRM;
                end
            end
            S_NRM: begin
                if (cnt_q < C_TC) begin
                    inst_d[I_DIV] = 1'b1;
                end else begin
                    state_d = S_NPW;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
        if (tile_end) begin
            cnt_d = '0;
            if (tile_q == T_LAST) begin
                state_d = S_IDLE;
                tile_d  = '0;
                done_d  = 1'b1;
            end else begin
                state_d = S_KWR;
                tile_d  = tile_q + TW'(1);
            end
        end
        if (abort) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            tile_d  = '0;
            norm_d  = 1'b0;
            inst_d  = '0;
            done_d  = 1'b0;
        end
    end

    // Negedge state update so inst is settled at the core's posedge.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            tile_q  <= '0;
            norm_q  <= 1'b0;
            inst_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tile_q  <= tile_d;
            norm_q  <= norm_d;
            inst_q  <= inst_d;
            done_q  <= done_d;
        end
    end

    assign inst = inst_q;
    assign busy = (state_q != S_IDLE);
    assign done = done_q;
endmodule

// File: tb/tb_attn_sequencer.sv
// Bench for attn_sequencer: two configurations checked every cycle
// against a phase-list model built from the sequencing rules.
module tb_attn_sequencer;
    localparam int AW = 4;
    localparam int IW = 12 + 2 * AW;

    localparam logic [11:0] F_FIFO = 12'h800;
    localparam logic [11:0] F_DIV  = 12'h400;
    localparam logic [11:0] F_ACC  = 12'h200;
    localparam logic [11:0] F_OF   = 12'h100;
    localparam logic [11:0] F_EX   = 12'h080;
    localparam logic [11:0] F_LD   = 12'h040;
    localparam logic [11:0] F_QRD  = 12'h020;
    localparam logic [11:0] F_QWR  = 12'h010;
    localparam logic [11:0] F_KRD  = 12'h008;
    localparam logic [11:0] F_KWR  = 12'h004;
    localparam logic [11:0] F_PRD  = 12'h002;
    localparam logic [11:0] F_PWR  = 12'h001;

    logic clk = 1'b0;
    logic reset, start, norm_en, abort, fifo_in_ready;
    logic [IW-1:0] inst0, inst1;
    logic busy0, busy1, done0, done1;

    always #5 clk = ~clk;

    attn_sequencer #(
        .col(8), .total_cycle(8), .num_ktile(2), .addr_w(AW), .drain(10)
    ) u_dut0 (
        .clk(clk), .reset(reset), .start(start), .norm_en(norm_en),
        .abort(abort), .fifo_in_ready(fifo_in_ready),
        .inst(inst0), .busy(busy0), .done(done0)
    );

    attn_sequencer #(
        .col(4), .total_cycle(4), .num_ktile(4), .addr_w(AW), .drain(6)
    ) u_dut1 (
        .clk(clk), .reset(reset), .start(start), .norm_en(norm_en),
        .abort(abort), .fifo_in_ready(fifo_in_ready),
        .inst(inst1), .busy(busy1), .done(done1)
    );

    int total = 0;
    int bad   = 0;

    logic [IW-1:0] e_inst [2][512];
    bit            e_wt   [2][512];
    int            e_len [2];
    int            ptr [2];
    bit            active [2];
    bit            nrm [2];
    int            waits [2];
    int            run_cyc [2];
    int            last_len [2];
    int            done_seen [2];
    int            pwr_seen [2];
    int            div_seen [2];

    function automatic int pcol(input int u);
        return (u == 0) ? 8 : 4;
    endfunction
    function automatic int ptc(input int u);
        return (u == 0) ? 8 : 4;
    endfunction
    function automatic int pnk(input int u);
        return (u == 0) ? 2 : 4;
    endfunction
    function automatic int pdr(input int u);
        return (u == 0) ? 10 : 6;
    endfunction

    task automatic cmp(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic put(input int u, input logic [11:0] s, input int qk,
                       input int pa, input bit wt);
        logic [AW-1:0] qa, pb;
        qa = AW'(qk);
        pb = AW'(pa);
        e_inst[u][e_len[u]] = {s[11:8], qa, pb, s[7:0]};
        e_wt[u][e_len[u]]   = wt;
        e_len[u]++;
    endtask

    // am: 0 no address, 1 qk address, 2 pmem address
    task automatic stream(input int u, input logic [11:0] s, input int am,
                          input int base, input int n);
        for (int i = 0; i < n; i++) begin
            put(u, s, (am == 1) ? base + i : 0, (am == 2) ? base + i : 0, 1'b0);
        end
        put(u, 12'h0, 0, 0, 1'b0);
    endtask

    task automatic idle(input int u, input int n);
        for (int i = 0; i < n; i++) put(u, 12'h0, 0, 0, 1'b0);
    endtask

    task automatic build(input int u, input bit nm);
        int c, tc, dr;
        c  = pcol(u);
        tc = ptc(u);
        dr = pdr(u);
        e_len[u] = 0;
        stream(u, F_QWR, 1, 0, tc);
        for (int t = 0; t < pnk(u); t++) begin
            stream(u, F_KWR, 1, t * c, c);
            put(u, F_LD, 0, 0, 1'b0);
            for (int i = 0; i < c; i++) put(u, F_LD | F_KRD, t * c + i, 0, 1'b0);
            put(u, 12'h0, 0, 0, 1'b0);
            idle(u, dr);
            stream(u, F_EX | F_QRD, 1, 0, tc);
            idle(u, dr);
            stream(u, F_OF | F_PWR, 2, t * tc, tc);
            if (nm) begin
                for (int i = 0; i <= tc; i++) begin
                    put(u, ((i < tc) ? F_PRD : 12'h0) | ((i > 0) ? F_ACC : 12'h0),
                        0, (i < tc) ? t * tc + i : 0, 1'b0);
                end
                stream(u, F_FIFO, 0, 0, tc);
                put(u, 12'h0, 0, 0, 1'b1);
                stream(u, F_DIV, 0, 0, tc);
                stream(u, F_OF | F_PWR, 2, t * tc, tc);
            end
        end
    endtask

    // One clock: compare both DUTs against the model at posedge.
    task automatic step();
        logic [IW-1:0] ei, di;
        logic eb, ed, db, dd;
        int exl, c, tc, k, dr;
        @(posedge clk);
        for (int u = 0; u < 2; u++) begin
            di = (u == 0) ? inst0 : inst1;
            db = (u == 0) ? busy0 : busy1;
            dd = (u == 0) ? done0 : done1;
            ei = '0;
            eb = 1'b0;
            ed = 1'b0;
            if (reset || abort) begin
                active[u] = 1'b0;
            end else if (!active[u]) begin
                if (start) begin
                    build(u, norm_en);
                    nrm[u]     = norm_en;
                    ptr[u]     = 0;
                    waits[u]   = 0;
                    run_cyc[u] = 0;
                    active[u]  = 1'b1;
                    eb         = 1'b1;
                end
            end else begin
                ei = e_inst[u][ptr[u]];
                if (e_wt[u][ptr[u]] && !fifo_in_ready) waits[u]++;
                else ptr[u]++;
                if (ptr[u] == e_len[u]) begin
                    ed        = 1'b1;
                    active[u] = 1'b0;
                end else begin
                    eb = 1'b1;
                end
            end
            if (eb) run_cyc[u]++;
            total++;
            if (di !== ei || db !== eb || dd !== ed) begin
                bad++;
                $display("FAIL cyc dut%0d t=%0t inst=%h want=%h busy=%b want=%b done=%b want=%b",
                         u, $time, di, ei, db, eb, dd, ed);
            end
            if (dd === 1'b1) done_seen[u]++;
            if (di[0] === 1'b1) pwr_seen[u]++;
            if (di[18] === 1'b1) div_seen[u]++;
            if (ed) begin
                c  = pcol(u);
                tc = ptc(u);
                k  = pnk(u);
                dr = pdr(u);
                exl = (tc + 1) + k * ((c + 1) + (c + 2) + dr + (tc + 1) + dr + (tc + 1));
                if (nrm[u]) exl += k * (4 * (tc + 1) + 1) + waits[u];
                last_len[u] = run_cyc[u];
                cmp("run_len", run_cyc[u], exl);
            end
        end
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int lim);
        int n;
        n = 0;
        while ((active[0] || active[1]) && n < lim) begin
            step();
            n++;
        end
        if (active[0] || active[1]) begin
            total++;
            bad++;
            $display("FAIL timeout got=busy want=idle t=%0t", $time);
            reset = 1'b1;
            step();
            reset = 1'b0;
            step();
        end
    endtask

    initial begin
        int n, d0, d1, p0, p1, v0, v1;
        reset = 1'b1;
        start = 1'b0;
        norm_en = 1'b0;
        abort = 1'b0;
        fifo_in_ready = 1'b0;
        for (int u = 0; u < 2; u++) begin
            active[u] = 1'b0;
            done_seen[u] = 0;
            pwr_seen[u] = 0;
            div_seen[u] = 0;
        end
        step();
        step();
        cmp("rst_inst", int'(inst0), 0);
        cmp("rst_busy", int'(busy0), 0);
        cmp("rst_done", int'(done1), 0);
        reset = 1'b0;
        step();

        // Run A: plain run with a start pulse while busy
        d0 = done_seen[0]; d1 = done_seen[1];
        p0 = pwr_seen[0];  p1 = pwr_seen[1];
        norm_en = 1'b0;
        pulse_start();
        repeat (30) step();
        pulse_start();
        wait_idle(2000);
        step();
        cmp("a_len0", last_len[0], 123);
        cmp("a_len1", last_len[1], 137);
        cmp("a_done0", done_seen[0] - d0, 1);
        cmp("a_done1", done_seen[1] - d1, 1);
        cmp("a_pwr0", pwr_seen[0] - p0, 16);
        cmp("a_pwr1", pwr_seen[1] - p1, 16);

        // Run B: normalisation, parked in WAIT_IN for 20 cycles
        p0 = pwr_seen[0]; p1 = pwr_seen[1];
        v0 = div_seen[0]; v1 = div_seen[1];
        norm_en = 1'b1;
        fifo_in_ready = 1'b0;
        pulse_start();
        repeat (5) step();
        norm_en = 1'b0;
        n = 0;
        while (!(active[0] && e_wt[0][ptr[0]]) && n < 600) begin
            step();
            n++;
        end
        cmp("b_reach_wait", int'(active[0] && e_wt[0][ptr[0]]), 1);
        repeat (20) step();
        fifo_in_ready = 1'b1;
        wait_idle(3000);
        fifo_in_ready = 1'b0;
        step();
        cmp("b_div0", div_seen[0] - v0, 16);
        cmp("b_div1", div_seen[1] - v1, 16);
        cmp("b_pwr0", pwr_seen[0] - p0, 32);
        cmp("b_pwr1", pwr_seen[1] - p1, 32);

        // Run C: abort during FETCH
        d0 = done_seen[0]; d1 = done_seen[1];
        norm_en = 1'b1;
        fifo_in_ready = 1'b1;
        pulse_start();
        n = 0;
        while (!(active[0] && e_inst[0][ptr[0]][1]) && n < 600) begin
            step();
            n++;
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        cmp("c_busy0", int'(busy0), 0);
        cmp("c_inst0", int'(inst0), 0);
        repeat (3) step();
        cmp("c_done0", done_seen[0] - d0, 0);
        cmp("c_done1", done_seen[1] - d1, 0);

        // Start and abort together while idle
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        step();
        cmp("sa_busy0", int'(busy0), 0);

        // Run D: async reset mid-EXEC, then a fresh run
        norm_en = 1'b0;
        pulse_start();
        n = 0;
        while (!(active[0] && e_inst[0][ptr[0]][7]) && n < 600) begin
            step();
            n++;
        end
        #2 reset = 1'b1;
        #1;
        cmp("d_inst0", int'(inst0), 0);
        cmp("d_inst1", int'(inst1), 0);
        cmp("d_busy0", int'(busy0), 0);
        step();
        reset = 1'b0;
        step();
        pulse_start();
        wait_idle(2000);

        // Randomised runs
        for (int r = 0; r < 4; r++) begin
            norm_en = 1'($urandom % 2);
            fifo_in_ready = 1'b0;
            pulse_start();
            n = 0;
            while ((active[0] || active[1]) && n < 4000) begin
                fifo_in_ready = ($urandom % 3 == 0);
                start = active[0] && active[1] && ($urandom % 16 == 0);
                norm_en = 1'($urandom % 2);
                step();
                n++;
            end
            start = 1'b0;
            wait_idle(10);
            repeat (2) step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
